// File: rtl/timer_pkg.sv
// Shared definitions for the timer bank: channel state encoding and
// a clog2 helper used to size the prescaler.
package timer_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // Bits needed to count 0..v-1, never less than 1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown timer channel.
// Ports: clk, rst (async, active-high), tick (count enable), load/val
// (latch reload value and counter), start, stop, periodic (auto-reload
// mode) in; counter, running, timeout (one-cycle pulse), expired (sticky) out.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] val,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  output logic [CNT_W-1:0] counter,
  output logic             running,
  output logic             timeout,
  output logic             expired
);

  logic             r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_reload;
  logic             r_expired;
  logic             r_timeout;

  logic             w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_reload_nxt;
  logic             w_expired_nxt;
  logic             w_timeout_nxt;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_reload  <= '0;
      r_expired <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_reload  <= w_reload_nxt;
      r_expired <= w_expired_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Next state, priority load > stop > start > tick
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_reload_nxt  = r_reload;
    w_expired_nxt = r_expired;
    w_timeout_nxt = 1'b0;
    if (load) begin
      w_reload_nxt  = val;
      w_cnt_nxt     = val;
      w_state_nxt   = ST_IDLE;
      w_expired_nxt = 1'b0;
    end else if (stop) begin
      w_state_nxt = ST_IDLE;
    end else if (start && (r_state == ST_IDLE) &&
                 ((r_cnt != '0) || (r_reload != '0))) begin
      // An exhausted counter restarts from the reload value, so RUN never holds 0
      if (r_cnt == '0) w_cnt_nxt = r_reload;
      w_state_nxt   = ST_RUN;
      w_expired_nxt = 1'b0;
    end else if (tick && (r_state == ST_RUN)) begin
      if (r_cnt == CNT_W'(1)) begin
        w_timeout_nxt = 1'b1;
        w_expired_nxt = 1'b1;
        if (periodic) begin
          w_cnt_nxt = r_reload;
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
    end
  end

  // Outputs come straight from registers
  always_comb begin
    counter = r_cnt;
    running = (r_state == ST_RUN);
    timeout = r_timeout;
    expired = r_expired;
  end

endmodule

// File: rtl/timer_bank.sv
// Bank of independent countdown timers sharing one prescaler.
// Ports: CLOCK_50, frame_reset (async, active-high); per-channel load,
// reload_val (CNT_W-bit slice per channel), start, stop, periodic in;
// per-channel counter, running, timeout, expired out.
module timer_bank
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                      CLOCK_50,
  input  logic                      frame_reset,
  input  logic [NUM_CH-1:0]         load,
  input  logic [NUM_CH*CNT_W-1:0]   reload_val,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         stop,
  input  logic [NUM_CH-1:0]         periodic,
  output logic [NUM_CH*CNT_W-1:0]   counter,
  output logic [NUM_CH-1:0]         running,
  output logic [NUM_CH-1:0]         timeout,
  output logic [NUM_CH-1:0]         expired
);

  localparam int unsigned PS_W = clog2(PRESCALE);

  logic [PS_W-1:0] r_presc;
  logic            w_tick;

  // Tick on the last prescaler count; with PRESCALE=1 this is always true
  assign w_tick = (r_presc == PS_W'(PRESCALE - 1));

  // Free-running shared prescaler
  always_ff @(posedge CLOCK_50 or posedge frame_reset) begin
    if (frame_reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PS_W'(1);
    end
  end

  // One channel per bit of the control vectors
  for (genvar gi = 0; gi < int'(NUM_CH); gi++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk     (CLOCK_50),
      .rst     (frame_reset),
      .tick    (w_tick),
      .load    (load[gi]),
      .val     (reload_val[gi*CNT_W +: CNT_W]),
      .start   (start[gi]),
      .stop    (stop[gi]),
      .periodic(periodic[gi]),
      .counter (counter[gi*CNT_W +: CNT_W]),
      .running (running[gi]),
      .timeout (timeout[gi]),
      .expired (expired[gi])
    );
  end

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: two instances (PRESCALE=4 and PRESCALE=1) share
// the same stimulus; a behavioural model predicts both on every cycle.
module tb_timer_bank;

  localparam int NCH = 4;
  localparam int CW  = 8;

  logic CLOCK_50 = 1'b0;
  logic frame_reset;
  logic [NCH-1:0]    load, start, stop, periodic;
  logic [NCH*CW-1:0] reload_val;

  logic [NCH*CW-1:0] c4, c1;
  logic [NCH-1:0]    r4, t4, e4, r1, t1, e1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  timer_bank #(.NUM_CH(NCH), .CNT_W(CW), .PRESCALE(4)) dut4 (
    .CLOCK_50(CLOCK_50), .frame_reset(frame_reset), .load(load),
    .reload_val(reload_val), .start(start), .stop(stop), .periodic(periodic),
    .counter(c4), .running(r4), .timeout(t4), .expired(e4));

  timer_bank #(.NUM_CH(NCH), .CNT_W(CW), .PRESCALE(1)) dut1 (
    .CLOCK_50(CLOCK_50), .frame_reset(frame_reset), .load(load),
    .reload_val(reload_val), .start(start), .stop(stop), .periodic(periodic),
    .counter(c1), .running(r1), .timeout(t1), .expired(e1));

  // ---------------- behavioural model ----------------
  int unsigned m_cnt [2][NCH];
  int unsigned m_rel [2][NCH];
  bit          m_run [2][NCH];
  bit          m_exp [2][NCH];
  bit          m_to  [2][NCH];
  int unsigned m_edges;

  function automatic int unsigned ps(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic model_clear();
    m_edges = 0;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < NCH; c++) begin
        m_cnt[i][c] = 0; m_rel[i][c] = 0;
        m_run[i][c] = 0; m_exp[i][c] = 0; m_to[i][c] = 0;
      end
  endtask

  initial begin
    bit tk;
    int unsigned v;
    model_clear();
    forever begin
      @(posedge CLOCK_50 or posedge frame_reset);
      if (frame_reset) begin
        model_clear();
      end else begin
        for (int i = 0; i < 2; i++) begin
          // a tick happens on every ps(i)-th edge counted from reset
          tk = ((m_edges % ps(i)) == ps(i) - 1);
          for (int c = 0; c < NCH; c++) begin
            v = int'(reload_val[c*CW +: CW]);
            m_to[i][c] = 0;
            if (load[c]) begin
              m_rel[i][c] = v; m_cnt[i][c] = v; m_run[i][c] = 0; m_exp[i][c] = 0;
            end else if (stop[c]) begin
              m_run[i][c] = 0;
            end else if (start[c] && !m_run[i][c] && (m_cnt[i][c] != 0 || m_rel[i][c] != 0)) begin
              if (m_cnt[i][c] == 0) m_cnt[i][c] = m_rel[i][c];
              m_run[i][c] = 1; m_exp[i][c] = 0;
            end else if (tk && m_run[i][c]) begin
              m_cnt[i][c] = m_cnt[i][c] - 1;
              if (m_cnt[i][c] == 0) begin
                m_to[i][c] = 1; m_exp[i][c] = 1;
                if (periodic[c]) m_cnt[i][c] = m_rel[i][c];
                else m_run[i][c] = 0;
              end
            end
          end
        end
        m_edges++;
      end
    end
  end

  function automatic logic [63:0] model_vec(input int i);
    logic [NCH*CW-1:0] c;
    logic [NCH-1:0] r, t, e;
    for (int k = 0; k < NCH; k++) begin
      c[k*CW +: CW] = CW'(m_cnt[i][k]);
      r[k] = m_run[i][k]; t[k] = m_to[i][k]; e[k] = m_exp[i][k];
    end
    return {20'd0, c, r, t, e};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  initial forever begin
    @(negedge CLOCK_50);
    chk("dut_p4 vs model", {20'd0, c4, r4, t4, e4}, model_vec(0));
    chk("dut_p1 vs model", {20'd0, c1, r1, t1, e1}, model_vec(1));
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic setv(input int ch, input int v);
    reload_val[ch*CW +: CW] = CW'(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, pulses, notrun, early;
    frame_reset = 1'b1;
    load = '0; start = '0; stop = '0; periodic = '0; reload_val = '0;
    repeat (2) nxt();
    chk("reset outputs p4", {20'd0, c4, r4, t4, e4}, 64'd0);
    chk("reset outputs p1", {20'd0, c1, r1, t1, e1}, 64'd0);

    // ch0 one-shot of 3 with PRESCALE=4: ticks on edges 4, 8, 12
    frame_reset = 1'b0;
    load[0] = 1'b1; setv(0, 3);
    nxt();
    chk("ch0 loaded", {56'd0, c4[7:0]}, 64'd3);
    chk("ch0 idle after load", 64'(r4[0]), 64'd0);
    load = '0; start[0] = 1'b1;
    nxt();
    start = '0;
    chk("ch0 running at 3", {55'd0, r4[0], c4[7:0]}, {55'd0, 1'b1, 8'd3});
    repeat (2) nxt();
    chk("ch0 count 2", {56'd0, c4[7:0]}, 64'd2);
    repeat (4) nxt();
    chk("ch0 count 1", {56'd0, c4[7:0]}, 64'd1);
    repeat (3) nxt();
    chk("ch0 no early timeout", 64'(t4[0]), 64'd0);
    nxt();
    chk("ch0 expiry {cnt,to,run,exp}", {53'd0, c4[7:0], t4[0], r4[0], e4[0]},
        {53'd0, 8'd0, 1'b1, 1'b0, 1'b1});
    nxt();
    chk("ch0 timeout one cycle", {62'd0, t4[0], e4[0]}, 64'd1);

    // ch1 periodic reload 2 for 20 ticks
    periodic[1] = 1'b1; load[1] = 1'b1; setv(1, 2);
    nxt();
    load = '0; start[1] = 1'b1;
    nxt();
    start = '0; pulses = 0; notrun = 0;
    repeat (80) begin
      nxt();
      pulses += int'(t4[1]);
      notrun += int'(!r4[1]);
    end
    chk("ch1 periodic pulses", 64'(pulses), 64'd10);
    chk("ch1 stays running", 64'(notrun), 64'd0);
    stop[1] = 1'b1;
    nxt();
    stop = '0; periodic = '0;

    // ch2 pause at 3, resume to expiry
    load[2] = 1'b1; setv(2, 5);
    nxt();
    load = '0; start[2] = 1'b1;
    nxt();
    start = '0; k = 0;
    while (c4[23:16] != 8'd3 && k < 40) begin nxt(); k++; end
    chk("ch2 reached 3", 64'(k < 40), 64'd1);
    stop[2] = 1'b1;
    nxt();
    stop = '0;
    repeat (32) nxt();
    chk("ch2 held {run,cnt}", {55'd0, r4[2], c4[23:16]}, {55'd0, 1'b0, 8'd3});
    start[2] = 1'b1;
    nxt();
    start = '0; k = 0;
    while (!t4[2] && k < 40) begin nxt(); k++; end
    chk("ch2 timeout after resume", {55'd0, t4[2], c4[23:16]}, {55'd0, 1'b1, 8'd0});

    // ch3 start with nothing loaded, then load/stop/start together
    start[3] = 1'b1;
    nxt();
    start = '0;
    chk("ch3 empty start ignored", {55'd0, r4[3], c4[31:24]}, 64'd0);
    load[3] = 1'b1; stop[3] = 1'b1; start[3] = 1'b1; setv(3, 1);
    nxt();
    load = '0; stop = '0; start = '0;
    chk("ch3 load wins", {55'd0, r4[3], c4[31:24]}, {55'd0, 1'b0, 8'd1});

    // ch0 load on the expiry edge
    load[0] = 1'b1; setv(0, 2);
    nxt();
    load = '0; start[0] = 1'b1;
    nxt();
    start = '0; k = 0;
    while (!(c4[7:0] == 8'd1 && (m_edges % 4) == 3) && k < 40) begin nxt(); k++; end
    chk("ch0 at expiry edge", 64'(k < 40), 64'd1);
    load[0] = 1'b1; setv(0, 7);
    nxt();
    load = '0;
    chk("ch0 load beats expiry", {53'd0, c4[7:0], t4[0], e4[0], r4[0]},
        {53'd0, 8'd7, 1'b0, 1'b0, 1'b0});
    nxt();
    chk("ch0 no late timeout", 64'(t4[0]), 64'd0);

    // async reset in the middle of a count on ch1
    load[1] = 1'b1; setv(1, 9);
    nxt();
    load = '0; start[1] = 1'b1;
    nxt();
    start = '0;
    repeat (6) nxt();
    @(posedge CLOCK_50);
    #1 frame_reset = 1'b1;
    #1;
    chk("async reset p4", {20'd0, c4, r4, t4, e4}, 64'd0);
    chk("async reset p1", {20'd0, c1, r1, t1, e1}, 64'd0);
    nxt();
    frame_reset = 1'b0; pulses = 0;
    repeat (40) begin nxt(); pulses += int'(|{t4, t1}); end
    chk("no pulse after reset", 64'(pulses), 64'd0);

    // PRESCALE=1: ch0 and ch2 loaded with 4, started together
    load[0] = 1'b1; load[2] = 1'b1; setv(0, 4); setv(2, 4);
    nxt();
    load = '0; start[0] = 1'b1; start[2] = 1'b1;
    nxt();
    start = '0; early = 0;
    repeat (3) begin nxt(); early += int'(|t1); end
    chk("p1 no early timeout", 64'(early), 64'd0);
    nxt();
    chk("p1 joint timeout", {60'd0, t1}, 64'b0101);

    // randomized traffic
    repeat (3000) begin
      for (int c = 0; c < NCH; c++) begin
        load[c]     = ($urandom_range(0, 15) == 0);
        start[c]    = ($urandom_range(0, 5) == 0);
        stop[c]     = ($urandom_range(0, 15) == 0);
        periodic[c] = 1'($urandom_range(0, 1));
        setv(c, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, 6)));
      end
      frame_reset = ($urandom_range(0, 499) == 0);
      nxt();
    end
    frame_reset = 1'b0;
    load = '0; start = '0; stop = '0; periodic = '0;
    repeat (4) nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
